div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions in the RISCV pipeline's functional-unit group. It is the multi-cycle consumer of unsigned magnitude comparison: each iteration asks whether the partial remainder is at least the divisor and, if so, subtracts. The execute stage issues with a start pulse and stalls on `busy`. The result returns with a one-cycle `valid` pulse and stays held until the next accepted start.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  issue request, sampled on `clk` rising edge
- `op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `rs1`  in  XLEN  dividend, captured on accepted start
- `rs2`  in  XLEN  divisor, captured on accepted start
- `flush`  in  1  abort in-flight operation (pipeline kill)
- `busy`  out  1  high while an operation is in flight (RUN state)
- `valid`  out  1  one-cycle pulse: `result` is new
- `result`  out  XLEN  quotient or remainder per captured `op`

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Accept: `start`=1 in IDLE or DONE, with `flush`=0. `start` in RUN is ignored.
- On accept, latch `op`. Signed ops (op[0]=0) take magnitudes of `rs1`/`rs2`. Record `neg_q` = sign(rs1) XOR sign(rs2) and `neg_r` = sign(rs1); both are 0 for unsigned ops.
- Special cases, resolved at accept with no iteration; next state is DONE:
  - Divisor 0: quotient = all ones, remainder = `rs1`.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, op[0]=0): quotient = 0x80000000, remainder = 0.
- Normal path: R (XLEN+1 bits) = 0; Q = |dividend|; D = |divisor|; iteration counter = 0. Next state is RUN.
- RUN, once per cycle:
  - T = {R[XLEN-1:0], Q[XLEN-1]}.
  - If T ≥ {1'b0, D} (unsigned): R = T − D and shift 1 into Q LSB.
  - Otherwise R = T and shift 0 into Q LSB.
  - Counter increments. After the XLEN-th iteration, go to DONE.
- Entering DONE: `result` = op[1] ? (neg_r ? −R : R) : (neg_q ? −Q : Q), truncated to XLEN bits. Two's-complement negation.
- DONE lasts one cycle with `valid`=1, then returns to IDLE unless a new start is accepted.
- `result` is held from DONE until the next DONE. It is not cleared on IDLE.
- `flush`=1 in any state: next state IDLE; `valid` is suppressed that cycle and the next.
  - `result` keeps its old value.
  - `flush` has priority over a simultaneous `start`.

## Timing
- Reset values: `busy`=0, `valid`=0, `result`=0. Internal R, Q, D, and counter are 0; state is IDLE.
- Normal latency: start accepted at edge k. `busy`=1 during cycles k+1 … k+XLEN. `valid`=1 in cycle k+XLEN+1 (33 cycles after the accept edge for XLEN=32).
- Special-case latency: `valid`=1 in cycle k+1; `busy` stays 0.
- Back-to-back: `start` during the DONE cycle is accepted, so a new RUN begins on the next edge with no idle gap.
- Reset asserted mid-RUN: all state and outputs return to reset values immediately (asynchronous). No `valid` is produced for the aborted operation.
- Outputs are registered; there is no combinational path from inputs to `busy`, `valid`, or `result`.

## Test plan
- DIVU 100/7 → `valid` at accept+33, `result`=14. REMU 100/7 → `result`=2. `busy` high for exactly 32 cycles.
- DIV −7/2 (0xFFFFFFF9, 2) → `result`=0xFFFFFFFD. REM same operands → 0xFFFFFFFF. REM 7/−2 → 1.
- DIVU 5/0 → `result`=0xFFFFFFFF at accept+1. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0. `busy` never rises in any of these.
- `flush` at RUN cycle 10 → no `valid`, `busy`=0 next cycle, `result` unchanged. Then DIVU 0xFFFFFFFF/3 → 0x55555555 with normal latency.
- `start` pulses during RUN are ignored. A `start` in the DONE cycle chains DIVU 9/3 then REMU 10/4 → `valid` pulses 33 cycles apart with results 3 and 2.
- `rst_n` low mid-RUN → `busy`/`valid`/`result` go to 0 immediately. After release, a new DIVU 20/6 → 3.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   issue request, accepted in IDLE or DONE when flush is low
//   op      in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1     in   dividend, captured on accept
//   rs2     in   divisor, captured on accept
//   flush   in   pipeline kill, aborts any in-flight operation
//   busy    out  high while iterating (RUN)
//   valid   out  one-cycle pulse when result is new
//   result  out  quotient or remainder, held until the next completion
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_next;

    // Captured operation context
    logic            is_rem_q;
    logic            neg_q_q;
    logic            neg_r_q;

    // Iteration datapath. The partial remainder is always below the divisor
    // after a step, so only the shifted trial value T needs the extra bit.
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;

    // Accept-time decode
    logic            accept;
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;

    // One restoring step
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] r_step;
    logic [XLEN-1:0] q_step;
    logic            last;
    logic [XLEN-1:0] r_signed;
    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] final_result;

    always_comb begin
        accept    = start && !flush && (state_q != S_RUN);
        is_signed = ~op[0];
        a_neg     = is_signed & rs1[XLEN-1];
        b_neg     = is_signed & rs2[XLEN-1];
        a_mag     = a_neg ? -rs1 : rs1;
        b_mag     = b_neg ? -rs2 : rs2;
        div_zero  = (rs2 == '0);
        overflow  = is_signed && (rs1 == SMIN) && (rs2 == '1);
        special   = div_zero || overflow;

        // Divide-by-zero wins over overflow: rs2 cannot be both 0 and -1.
        if (div_zero) begin
            special_result = op[1] ? rs1 : '1;
        end else begin
            special_result = op[1] ? '0 : SMIN;
        end
    end

    always_comb begin
        trial  = {rem_q, quo_q[XLEN-1]};
        ge     = (trial >= {1'b0, dvs_q});
        // Low bits of T - D are exact because the true difference fits in XLEN.
        r_step = ge ? (trial[XLEN-1:0] - dvs_q) : trial[XLEN-1:0];
        q_step = {quo_q[XLEN-2:0], ge};
        last   = (cnt_q == LAST_CNT);

        r_signed     = neg_r_q ? -r_step : r_step;
        q_signed     = neg_q_q ? -q_step : q_step;
        final_result = is_rem_q ? r_signed : q_signed;
    end

    // Next-state logic; flush overrides everything including a new start.
    always_comb begin
        state_next = state_q;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_next = special ? S_DONE : S_RUN;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (last) begin
                        state_next = S_DONE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Outputs are registered copies of the next state so they carry no
    // combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            busy  <= (state_next == S_RUN);
            valid <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result   <= '0;
        end else if (!flush) begin
            if (accept) begin
                is_rem_q <= op[1];
                neg_q_q  <= a_neg ^ b_neg;
                neg_r_q  <= a_neg;
                rem_q    <= '0;
                quo_q    <= a_mag;
                dvs_q    <= b_mag;
                cnt_q    <= '0;
                if (special) begin
                    result <= special_result;
                end
            end else if (state_q == S_RUN) begin
                rem_q <= r_step;
                quo_q <= q_step;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    result <= final_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_checks;
    int n_errors;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V division semantics in plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit ref_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Cycle-level expectation: a countdown of remaining busy cycles plus
    // the pending answer.
    int          m_left;
    logic        m_busy;
    logic        m_valid;
    logic [31:0] m_result;
    logic [31:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_result <= 32'd0;
            m_pend   <= 32'd0;
        end else if (flush) begin
            m_left  <= 0;
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_left == 0 && start) begin
            if (ref_special(op, rs1, rs2)) begin
                m_valid  <= 1'b1;
                m_busy   <= 1'b0;
                m_result <= ref_div(op, rs1, rs2);
            end else begin
                m_left  <= 32;
                m_busy  <= 1'b1;
                m_valid <= 1'b0;
                m_pend  <= ref_div(op, rs1, rs2);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_valid  <= 1'b1;
                m_result <= m_pend;
            end
        end else begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
            chk("cyc_result", result, m_result);
        end
    endtask

    // Called at a negedge; returns at the negedge of the valid cycle.
    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int exp_busy);
        int n;
        int nb;
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(negedge clk);
        start = 1'b0;
        n  = 1;
        nb = 0;
        while (!valid && n < 40) begin
            nb += int'(busy);
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, {31'd0, valid}, 32'd1);
        chk(name, result, exp);
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_busycycles"}, 32'(nb), 32'(exp_busy));
    endtask

    function automatic logic [31:0] rand_operand(input bit divisor);
        case ($urandom_range(0, 5))
            0:       return divisor ? 32'd0 : 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            3:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        bit saw_valid;
        logic [31:0] held;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'd0;
        rs1   = 32'd0;
        rs2   = 32'd0;

        fork
            compare_loop();
        join_none

        chk("model_div_neg", ref_div(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem_neg", ref_div(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_rem_negdiv", ref_div(2'd2, 32'd7, 32'hFFFF_FFFE), 32'd1);
        chk("model_remu", ref_div(2'd3, 32'd100, 32'd7), 32'd2);

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 33, 32);
        do_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33, 32);
        do_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
        do_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
        do_op("rem_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 32);

        // Flush in the tenth RUN cycle
        held  = result;
        start = 1'b1;
        op    = 2'd1;
        rs1   = 32'd1000;
        rs2   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        chk("flush_result", result, held);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        chk("flush_no_valid", {31'd0, saw_valid}, 32'd0);
        do_op("divu_max_3", 2'd1, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, 32);

        do_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        do_op("rem_5_0", 2'd2, 32'd5, 32'd0, 32'd5, 1, 0);
        do_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        @(negedge clk);

        // start pulses during RUN must be ignored
        start = 1'b1;
        op    = 2'd1;
        rs1   = 32'd1000;
        rs2   = 32'd10;
        @(negedge clk);
        n = 1;
        while (!valid && n < 40) begin
            start = (n == 5 || n == 20);
            op    = 2'd2;
            rs2   = 32'd0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ignore_start_result", result, 32'd100);
        chk("ignore_start_latency", 32'(n), 32'd33);

        // Back-to-back: second start issued in the DONE cycle
        do_op("chain_divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 33, 32);
        do_op("chain_remu_10_4", 2'd3, 32'd10, 32'd4, 32'd2, 33, 32);

        // Asynchronous reset in the middle of RUN
        start = 1'b1;
        op    = 2'd1;
        rs1   = 32'd5000;
        rs2   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("divu_20_6", 2'd1, 32'd20, 32'd6, 32'd3, 33, 32);

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 6000; c++) begin
            start = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 199) < 3);
            op    = 2'($urandom_range(0, 3));
            rs1   = rand_operand(1'b0);
            rs2   = rand_operand(1'b1);
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
